stream_omega_rsp_tracker: RTL and testbench
===========================================

# stream_omega_rsp_tracker

Per-output transaction tracker placed directly downstream of each `stream_omega_net` output port. It forwards request beats to the attached slave and records the `idx_o` source index of every accepted beat in an in-order FIFO. Returning slave responses are tagged with the recorded index as `rsp_sel_o`, so they can be routed back to the originating input through a response-direction `stream_omega_net`. It limits outstanding transactions per output to `Depth`.

## Interface
- `NumInp`, 32'd0: number of network inputs; `> 0`.
- `Depth`, 32'd4: maximum outstanding transactions; `>= 1`, any value (not restricted to powers of two).
- `req_t`, `logic`: request payload type.
- `rsp_t`, `logic`: response payload type.
- `IdxWidth`, derived: `(NumInp > 1) ? $clog2(NumInp) : 1`; do not override.
- `CntWidth`, derived: `$clog2(Depth+1)`; do not override.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous reset, active-high.
- `flush_i`  in  1  synchronous clear of the tracking FIFO.
- `req_data_i`  in  req_t  request from network output `data_o`.
- `req_idx_i`  in  IdxWidth  source index from network `idx_o`.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted.
- `req_data_o`  out  req_t  request to slave.
- `req_valid_o`  out  1  request valid to slave.
- `req_ready_i`  in  1  slave accepts request.
- `rsp_data_i`  in  rsp_t  slave response.
- `rsp_valid_i`  in  1  response valid.
- `rsp_ready_o`  out  1  response accepted.
- `rsp_data_o`  out  rsp_t  response toward the return network.
- `rsp_sel_o`  out  IdxWidth  return-network output select, equal to the recorded source index.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  return network accepts.
- `usage_o`  out  CntWidth  outstanding transactions.
- `err_o`  out  1  one-cycle pulse: `rsp_valid_i` asserted while the FIFO is empty.

## Operation
- FIFO: `Depth` entries of `IdxWidth` bits, write pointer, read pointer, occupancy counter. Pointers wrap from `Depth-1` to 0.
- Request path (combinational):
  - `req_data_o = req_data_i`.
  - `req_valid_o = req_valid_i & ~full`.
  - `req_ready_o = req_ready_i & ~full`.
  - Push `req_idx_i` when `req_valid_i & req_ready_o`.
- Response path:
  - `rsp_valid_o = rsp_valid_i & ~empty`.
  - `rsp_ready_o = rsp_ready_i & ~empty`.
  - `rsp_sel_o` = FIFO head.
  - `rsp_data_o = rsp_data_i`.
  - Pop when `rsp_valid_i & rsp_ready_o`.
- Full blocks a push even if a pop occurs in the same cycle; there is no ready path from response to request.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged, both pointers advance.
- Responses are strictly in order. The slave must return responses in request order.
- Empty with `rsp_valid_i=1`: `rsp_ready_o=0`, `rsp_valid_o=0`, `err_o=1` for that cycle; the response is held off and not dropped.
- `flush_i`: next cycle both pointers=0 and usage=0. A push or pop in the flush cycle is ignored. Flush is legal only with no beats in flight.
- AXI handshake rules apply on all three streams: valid is not withdrawn without ready, and payload is stable while valid.

## Timing
- Request and response paths: 0-cycle latency. The FIFO state updates on the handshake edge.
- `full` and `empty` are registered-state decodes and have no combinational dependence on valid or ready.
- Reset values: pointers=0, `usage_o=0`, `req_valid_o=0` (when `req_valid_i=0`), `rsp_valid_o=0`, `err_o=0`, `req_ready_o=req_ready_i`, `rsp_ready_o=0`.
- Reset asserted mid-operation: all tracking is discarded immediately (asynchronous). Outstanding slave responses arriving afterwards raise `err_o`.

## Configuration
- `STREAM_OMEGA_RSP_TRACKER_SPILL_EN` defined: a `spill_register` sits on the response output (`rsp_data_o`, `rsp_sel_o`, `rsp_valid_o`).
  - Response latency becomes 1 cycle.
  - `rsp_ready_o` depends only on spill-register state and `~empty`, not combinationally on `rsp_ready_i`.
  - The pop occurs on handshake into the spill register.
- Undefined: the response path is combinational as described above.

## Test plan
- Reset, then idle: all valids are 0, `usage_o=0`, `err_o=0`.
- `Depth=4`, `NumInp=8`: push idx 3,5,7,1 with `rsp_valid_i=0` -> `usage_o=4`, `req_ready_o=0`, `req_valid_o=0`; a fifth request is held.
- Return 4 responses -> `rsp_sel_o` sequence 3,5,7,1; `usage_o` back to 0.
- Full state plus a simultaneous response and request -> the pop happens and the push is blocked; next cycle `usage_o=3` and the request is accepted, giving 4.
- `Depth=3` (non-power-of-two): 10 push/pop pairs -> pointers wrap correctly and `rsp_sel_o` matches the pushed order.
- Empty FIFO with `rsp_valid_i=1` -> `err_o=1`, `rsp_ready_o=0`. Assert `rst_i` with 2 outstanding -> `usage_o=0` asynchronously.

Source files
------------

// File: rtl/stream_omega_rsp_tracker.sv
// stream_omega_rsp_tracker
// Per-output transaction tracker for a stream_omega_net output port.
// The source index of each accepted request is stored in an in-order FIFO.
// Each returning response is tagged with the stored index in rsp_sel_o.
// Optional feature macro: STREAM_OMEGA_RSP_TRACKER_SPILL_EN. When it is
// defined, a two-entry spill register sits on the response output.
module stream_omega_rsp_tracker #(
   parameter int unsigned NumInp   = 32'd0,
   parameter int unsigned Depth    = 32'd4,
   parameter type         req_t    = logic,
   parameter type         rsp_t    = logic,
   parameter int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1,
   parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  req_t                req_data_i,
   input  logic [IdxWidth-1:0] req_idx_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   output req_t                req_data_o,
   output logic                req_valid_o,
   input  logic                req_ready_i,
   input  rsp_t                rsp_data_i,
   input  logic                rsp_valid_i,
   output logic                rsp_ready_o,
   output rsp_t                rsp_data_o,
   output logic [IdxWidth-1:0] rsp_sel_o,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [CntWidth-1:0] usage_o,
   output logic                err_o
);

   localparam int unsigned          PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
   localparam logic [CntWidth-1:0] FullCnt  = CntWidth'(Depth);

   logic [IdxWidth-1:0] mem_q [Depth];
   logic [PtrWidth-1:0] wr_ptr_q;
   logic [PtrWidth-1:0] rd_ptr_q;
   logic [CntWidth-1:0] usage_q;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;
   logic [IdxWidth-1:0] head_idx;

   // full and empty come from registered occupancy only, never from valid/ready
   assign full     = (usage_q == FullCnt);
   assign empty    = (usage_q == '0);
   assign head_idx = mem_q[rd_ptr_q];
   assign usage_o  = usage_q;
   assign err_o    = rsp_valid_i & empty;

   // Request path: a full FIFO blocks the request even if a pop happens in the same cycle
   assign req_data_o  = req_data_i;
   assign req_valid_o = req_valid_i & ~full;
   assign req_ready_o = req_ready_i & ~full;
   assign push        = req_valid_i & req_ready_o;

`ifdef STREAM_OMEGA_RSP_TRACKER_SPILL_EN
   logic [1:0]          sp_cnt_q;
   logic                sp_wr_q;
   logic                sp_rd_q;
   rsp_t                sp_data_q [2];
   logic [IdxWidth-1:0] sp_sel_q  [2];
   logic                sp_out;

   // The response enters the spill register, so ready depends only on its fill level
   assign rsp_ready_o = ~empty & (sp_cnt_q != 2'd2);
   assign pop         = rsp_valid_i & rsp_ready_o;
   assign rsp_valid_o = (sp_cnt_q != 2'd0);
   assign rsp_data_o  = sp_data_q[sp_rd_q];
   assign rsp_sel_o   = sp_sel_q[sp_rd_q];
   assign sp_out      = rsp_valid_o & rsp_ready_i;

   // Spill register slot pointers and fill level
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sp_cnt_q <= '0;
         sp_wr_q  <= 1'b0;
         sp_rd_q  <= 1'b0;
      end else if (flush_i) begin
         sp_cnt_q <= '0;
         sp_wr_q  <= 1'b0;
         sp_rd_q  <= 1'b0;
      end else begin
         if (pop) sp_wr_q <= ~sp_wr_q;
         if (sp_out) sp_rd_q <= ~sp_rd_q;
         if (pop && !sp_out) sp_cnt_q <= sp_cnt_q + 2'd1;
         else if (!pop && sp_out) sp_cnt_q <= sp_cnt_q - 2'd1;
      end
   end

   // Spill register payload storage
   always_ff @(posedge clk_i) begin
      if (pop) begin
         sp_data_q[sp_wr_q] <= rsp_data_i;
         sp_sel_q[sp_wr_q]  <= head_idx;
      end
   end
`else
   // Combinational response path tagged with the FIFO head
   assign rsp_ready_o = rsp_ready_i & ~empty;
   assign rsp_valid_o = rsp_valid_i & ~empty;
   assign rsp_data_o  = rsp_data_i;
   assign rsp_sel_o   = head_idx;
   assign pop         = rsp_valid_i & rsp_ready_o;
`endif

   // Index storage, written on every accepted request
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= req_idx_i;
   end

   // Pointers and occupancy; flush discards the tracking and any push/pop in that cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         usage_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         usage_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
         if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
         if (push && !pop) usage_q <= usage_q + CntWidth'(1);
         else if (!push && pop) usage_q <= usage_q - CntWidth'(1);
      end
   end

endmodule

// File: tb/tb_stream_omega_rsp_tracker.sv
// Testbench for stream_omega_rsp_tracker (default build, combinational response path).
// Two instances with NumInp=8 share one set of inputs: Depth=4 and Depth=3.
// Each instance is checked against its own queue model.
module tb_stream_omega_rsp_tracker;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       req_data;
   logic [2:0] req_idx;
   logic       req_valid;
   logic       slv_ready;
   logic       rsp_data;
   logic       rsp_valid;
   logic       net_ready;

   logic       d4_req_ready, d4_req_data, d4_req_valid, d4_rsp_ready, d4_rsp_data, d4_rsp_valid, d4_err;
   logic [2:0] d4_rsp_sel;
   logic [2:0] d4_usage;
   logic       d3_req_ready, d3_req_data, d3_req_valid, d3_rsp_ready, d3_rsp_data, d3_rsp_valid, d3_err;
   logic [2:0] d3_rsp_sel;
   logic [1:0] d3_usage;

   int checks = 0;
   int passes = 0;
   int q4[$];
   int q3[$];

   always #5 clk = ~clk;

   stream_omega_rsp_tracker #(.NumInp(8), .Depth(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .req_data_i(req_data), .req_idx_i(req_idx), .req_valid_i(req_valid), .req_ready_o(d4_req_ready),
      .req_data_o(d4_req_data), .req_valid_o(d4_req_valid), .req_ready_i(slv_ready),
      .rsp_data_i(rsp_data), .rsp_valid_i(rsp_valid), .rsp_ready_o(d4_rsp_ready),
      .rsp_data_o(d4_rsp_data), .rsp_sel_o(d4_rsp_sel), .rsp_valid_o(d4_rsp_valid), .rsp_ready_i(net_ready),
      .usage_o(d4_usage), .err_o(d4_err)
   );

   stream_omega_rsp_tracker #(.NumInp(8), .Depth(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .req_data_i(req_data), .req_idx_i(req_idx), .req_valid_i(req_valid), .req_ready_o(d3_req_ready),
      .req_data_o(d3_req_data), .req_valid_o(d3_req_valid), .req_ready_i(slv_ready),
      .rsp_data_i(rsp_data), .rsp_valid_i(rsp_valid), .rsp_ready_o(d3_rsp_ready),
      .rsp_data_o(d3_rsp_data), .rsp_sel_o(d3_rsp_sel), .rsp_valid_o(d3_rsp_valid), .rsp_ready_i(net_ready),
      .usage_o(d3_usage), .err_o(d3_err)
   );

   // Advance one clock edge and update the queue models from the spec's handshake rules
   task automatic step();
      bit p4, o4, p3, o3;
      p4 = req_valid && slv_ready && (q4.size() < 4);
      o4 = rsp_valid && net_ready && (q4.size() > 0);
      p3 = req_valid && slv_ready && (q3.size() < 3);
      o3 = rsp_valid && net_ready && (q3.size() > 0);
      @(posedge clk);
      if (flush) begin
         q4.delete();
         q3.delete();
      end else begin
         if (o4) void'(q4.pop_front());
         if (p4) q4.push_back(int'(req_idx));
         if (o3) void'(q3.pop_front());
         if (p3) q3.push_back(int'(req_idx));
      end
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; req_valid = 0; rsp_valid = 0; slv_ready = 1; net_ready = 1;
      req_data = 0; rsp_data = 0; req_idx = 0;
   endtask

   task automatic drain();
      idle_inputs();
      rsp_valid = 1;
      for (int i = 0; i < 8 && (q4.size() > 0 || q3.size() > 0); i++) step();
      rsp_valid = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      #12;
      checks++;
      if ({d4_usage, d4_req_valid, d4_rsp_valid, d4_err, d4_req_ready, d4_rsp_ready} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0})
         $display("[TB] FAIL reset_d4: got %b expected %b",
                  {d4_usage, d4_req_valid, d4_rsp_valid, d4_err, d4_req_ready, d4_rsp_ready}, 8'b000_00010);
      else passes++;
      checks++;
      if ({d3_usage, d3_req_valid, d3_rsp_valid, d3_err, d3_rsp_ready} !== 6'b0)
         $display("[TB] FAIL reset_d3: got %b expected 000000",
                  {d3_usage, d3_req_valid, d3_rsp_valid, d3_err, d3_rsp_ready});
      else passes++;
      @(negedge clk);
      rst = 0;
      step();
   endtask

   task automatic test_fill();
      int seq[4] = '{3, 5, 7, 1};
      idle_inputs();
      foreach (seq[i]) begin
         req_idx = 3'(seq[i]);
         req_valid = 1;
         #1;
         checks++;
         if (d4_req_ready !== 1'b1) $display("[TB] FAIL fill_ready: got %b expected 1", d4_req_ready);
         else passes++;
         step();
      end
      req_idx = 3'd6;
      #1;
      checks++;
      if ({d4_usage, d4_req_ready, d4_req_valid} !== {3'd4, 1'b0, 1'b0})
         $display("[TB] FAIL fill_full: got usage=%0d ready=%b valid=%b expected usage=4 ready=0 valid=0",
                  d4_usage, d4_req_ready, d4_req_valid);
      else passes++;
      step();
      checks++;
      if (d4_usage !== 3'd4) $display("[TB] FAIL fill_held: got usage=%0d expected 4", d4_usage);
      else passes++;
      req_valid = 0;
   endtask

   task automatic test_drain();
      int seq[4] = '{3, 5, 7, 1};
      idle_inputs();
      rsp_valid = 1;
      foreach (seq[i]) begin
         #1;
         checks++;
         if (d4_rsp_sel !== 3'(seq[i]) || d4_rsp_valid !== 1'b1)
            $display("[TB] FAIL drain_sel%0d: got sel=%0d valid=%b expected sel=%0d valid=1",
                     i, d4_rsp_sel, d4_rsp_valid, seq[i]);
         else passes++;
         step();
      end
      rsp_valid = 0;
      #1;
      checks++;
      if (d4_usage !== 3'd0) $display("[TB] FAIL drain_usage: got %0d expected 0", d4_usage);
      else passes++;
   endtask

   task automatic test_full_pop_push();
      idle_inputs();
      req_valid = 1;
      for (int i = 0; i < 4; i++) begin
         req_idx = 3'($urandom_range(0, 7));
         step();
      end
      rsp_valid = 1;
      #1;
      checks++;
      if ({d4_req_ready, d4_rsp_ready} !== 2'b01)
         $display("[TB] FAIL full_simul: got req_ready=%b rsp_ready=%b expected 0 1", d4_req_ready, d4_rsp_ready);
      else passes++;
      step();
      rsp_valid = 0;
      #1;
      checks++;
      if (d4_usage !== 3'd3 || d4_req_ready !== 1'b1)
         $display("[TB] FAIL full_after_pop: got usage=%0d ready=%b expected 3 1", d4_usage, d4_req_ready);
      else passes++;
      step();
      checks++;
      if (d4_usage !== 3'd4) $display("[TB] FAIL full_refill: got usage=%0d expected 4", d4_usage);
      else passes++;
      req_valid = 0;
   endtask

   task automatic test_wrap();
      int v;
      idle_inputs();
      for (int i = 0; i < 10; i++) begin
         v = $urandom_range(0, 7);
         req_idx = 3'(v);
         req_valid = 1;
         rsp_valid = 0;
         step();
         req_valid = 0;
         rsp_valid = 1;
         #1;
         checks++;
         if (d3_rsp_sel !== 3'(v) || d3_usage !== 2'd1)
            $display("[TB] FAIL wrap_d3_%0d: got sel=%0d usage=%0d expected sel=%0d usage=1", i, d3_rsp_sel, d3_usage, v);
         else passes++;
         step();
      end
      rsp_valid = 0;
   endtask

   task automatic test_err();
      idle_inputs();
      rsp_valid = 1;
      #1;
      checks++;
      if ({d4_err, d4_rsp_ready, d4_rsp_valid, d3_err} !== 4'b1001)
         $display("[TB] FAIL err_empty: got err=%b ready=%b valid=%b err3=%b expected 1 0 0 1",
                  d4_err, d4_rsp_ready, d4_rsp_valid, d3_err);
      else passes++;
      step();
      rsp_valid = 0;
      #1;
      checks++;
      if (d4_err !== 1'b0) $display("[TB] FAIL err_clear: got %b expected 0", d4_err);
      else passes++;
   endtask

   task automatic test_flush();
      idle_inputs();
      req_valid = 1;
      req_idx = 3'd2;
      step();
      step();
      flush = 1;
      rsp_valid = 1;
      step();
      idle_inputs();
      #1;
      checks++;
      if (d4_usage !== 3'(q4.size()) || d3_usage !== 2'(q3.size()) || d4_usage !== 3'd0)
         $display("[TB] FAIL flush: got usage4=%0d usage3=%0d expected 0 0", d4_usage, d3_usage);
      else passes++;
   endtask

   task automatic test_async_reset();
      idle_inputs();
      req_valid = 1;
      req_idx = 3'd4;
      step();
      step();
      req_valid = 0;
      #2;
      rst = 1;
      #1;
      q4.delete();
      q3.delete();
      checks++;
      if (d4_usage !== 3'd0 || d3_usage !== 2'd0)
         $display("[TB] FAIL async_reset: got usage4=%0d usage3=%0d expected 0 0", d4_usage, d3_usage);
      else passes++;
      @(negedge clk);
      rst = 0;
      rsp_valid = 1;
      #1;
      checks++;
      if (d4_err !== 1'b1 || d4_rsp_valid !== 1'b0)
         $display("[TB] FAIL post_reset_err: got err=%b valid=%b expected 1 0", d4_err, d4_rsp_valid);
      else passes++;
      step();
      rsp_valid = 0;
   endtask

   task automatic test_random();
      logic [9:0] e4, a4;
      logic [8:0] e3, a3;
      for (int c = 0; c < 400; c++) begin
         flush     = ($urandom_range(0, 31) == 0);
         req_valid = $urandom_range(0, 1);
         slv_ready = ($urandom_range(0, 3) != 0);
         rsp_valid = $urandom_range(0, 1);
         net_ready = ($urandom_range(0, 3) != 0);
         req_idx   = 3'($urandom_range(0, 7));
         req_data  = $urandom_range(0, 1);
         rsp_data  = $urandom_range(0, 1);
         #1;
         e4 = {3'(q4.size()), slv_ready && (q4.size() < 4), req_valid && (q4.size() < 4),
               rsp_valid && (q4.size() > 0), net_ready && (q4.size() > 0), rsp_valid && (q4.size() == 0),
               req_data, rsp_data};
         a4 = {d4_usage, d4_req_ready, d4_req_valid, d4_rsp_valid, d4_rsp_ready, d4_err, d4_req_data, d4_rsp_data};
         checks++;
         if (a4 !== e4) $display("[TB] FAIL rand_d4 cycle %0d: got %b expected %b", c, a4, e4);
         else passes++;
         e3 = {2'(q3.size()), slv_ready && (q3.size() < 3), req_valid && (q3.size() < 3),
               rsp_valid && (q3.size() > 0), net_ready && (q3.size() > 0), rsp_valid && (q3.size() == 0),
               req_data, rsp_data};
         a3 = {d3_usage, d3_req_ready, d3_req_valid, d3_rsp_valid, d3_rsp_ready, d3_err, d3_req_data, d3_rsp_data};
         checks++;
         if (a3 !== e3) $display("[TB] FAIL rand_d3 cycle %0d: got %b expected %b", c, a3, e3);
         else passes++;
         if (q4.size() > 0) begin
            checks++;
            if (d4_rsp_sel !== 3'(q4[0])) $display("[TB] FAIL rand_sel4 cycle %0d: got %0d expected %0d", c, d4_rsp_sel, q4[0]);
            else passes++;
         end
         if (q3.size() > 0) begin
            checks++;
            if (d3_rsp_sel !== 3'(q3[0])) $display("[TB] FAIL rand_sel3 cycle %0d: got %0d expected %0d", c, d3_rsp_sel, q3[0]);
            else passes++;
         end
         step();
      end
      idle_inputs();
   endtask

   // Test sequence
   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_full_pop_push();
      drain();
      test_wrap();
      drain();
      test_err();
      test_flush();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
